// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
// Optional build macro used by this slice: REGFILE_WB_FWD_EN (writeback forward compare).
package regfile_pkg;

  localparam int DEF_NREQ           = 3;
  localparam int DEF_REGISTER_WIDTH = 32;
  localparam int DEF_IDX_W          = 5;

  // x0 is hardwired to zero; writes to it are accepted and dropped
  localparam int REG_ZERO = 0;

  // Requester slots on the writeback arbiter
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and register_file.
// REGFILE_WB_FWD_EN adds the read-index compare signals.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ           = DEF_NREQ,
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int IDX_W          = DEF_IDX_W
);

  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [NREQ*IDX_W-1:0]          req_rd_idx;
  logic [NREQ*REGISTER_WIDTH-1:0] req_data;
  logic [IDX_W-1:0]               rf_rd_idx;
  logic [REGISTER_WIDTH-1:0]      rf_data_in;
  logic                           rf_write_en;
`ifdef REGFILE_WB_FWD_EN
  logic [IDX_W-1:0]               rs1_idx;
  logic [IDX_W-1:0]               rs2_idx;
  logic                           rs1_hit;
  logic                           rs2_hit;
`endif

  // Requesters / register_file / issue side
  modport master (
    output req_valid, req_rd_idx, req_data,
    input  req_ready, rf_rd_idx, rf_data_in, rf_write_en
`ifdef REGFILE_WB_FWD_EN
    , output rs1_idx, rs2_idx
    , input  rs1_hit, rs2_hit
`endif
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_rd_idx, req_data,
    output req_ready, rf_rd_idx, rf_data_in, rf_write_en
`ifdef REGFILE_WB_FWD_EN
    , input  rs1_idx, rs2_idx
    , output rs1_hit, rs2_hit
`endif
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Scan ptr, ptr+1, ... modulo N and grant the first active request
  always_comb begin : scan
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file's single write port among NREQ
// writeback requesters, with one registered output stage.
// REGFILE_WB_FWD_EN: adds rs1/rs2 hit compare against the staged write.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ           = DEF_NREQ,
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int IDX_W          = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             ptr_nxt;
  logic [PW-1:0]             gnt_idx;
  logic [NREQ-1:0]           req_ce;
  logic [NREQ-1:0]           gnt;
  logic                      xfer;
  logic [IDX_W-1:0]          sel_idx;
  logic [REGISTER_WIDTH-1:0] sel_data;

  // With ce low nobody is granted, so nothing can transfer
  assign req_ce = ce ? bus.req_valid : '0;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (req_ce),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |gnt;
  assign sel_idx       = bus.req_rd_idx[int'(gnt_idx)*IDX_W +: IDX_W];
  assign sel_data      = bus.req_data[int'(gnt_idx)*REGISTER_WIDTH +: REGISTER_WIDTH];
  assign ptr_nxt       = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  // Output stage: capture the winner; x0 targets are accepted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      bus.rf_write_en <= 1'b0;
      bus.rf_rd_idx   <= '0;
      bus.rf_data_in  <= '0;
    end else if (ce) begin
      if (xfer) begin
        rr_ptr          <= ptr_nxt;
        bus.rf_rd_idx   <= sel_idx;
        bus.rf_data_in  <= sel_data;
        bus.rf_write_en <= (sel_idx != IDX_W'(REG_ZERO));
      end else begin
        bus.rf_write_en <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // A read issued against the staged index must take rf_data_in instead
  assign bus.rs1_hit = bus.rf_write_en & (bus.rs1_idx == bus.rf_rd_idx);
  assign bus.rs2_hit = bus.rf_write_en & (bus.rs2_idx == bus.rf_rd_idx);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected grants and commits are
// queued at stimulus time and popped by a negedge monitor.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int RW   = 32;
  localparam int IW   = 5;

  typedef struct packed {
    logic [1:0]    g;
    logic [IW-1:0] idx;
    logic [RW-1:0] data;
  } row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .REGISTER_WIDTH(RW), .IDX_W(IW)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .REGISTER_WIDTH(RW), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  logic [NREQ-1:0] v;
  logic [IW-1:0]   ix [NREQ];
  logic [RW-1:0]   dt [NREQ];

  assign bus.req_valid  = v;
  assign bus.req_rd_idx = {ix[2], ix[1], ix[0]};
  assign bus.req_data   = {dt[2], dt[1], dt[0]};

  int n_chk  = 0;
  int n_pass = 0;

  int unsigned        gq [$];
  logic [IW+RW-1:0]   wq [$];

  row_t rows [6];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a grant seen with ce=1 transfers at the next edge; a staged
  // write seen with ce=1 commits to register_file at the next edge
  always @(negedge clk) begin
    if (rst_n && ce && bus.req_ready != '0) begin
      if (gq.size() == 0) begin
        n_chk++;
        $display("FAIL grant_unexpected: got %0b expected none", bus.req_ready);
      end else begin
        check("grant_order", 64'(bus.req_ready), 64'(1) << gq.pop_front());
      end
    end
    if (rst_n && ce && bus.rf_write_en) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL commit_unexpected: got idx %0d data %0h expected none",
                 bus.rf_rd_idx, bus.rf_data_in);
      end else begin
        check("commit", 64'({bus.rf_rd_idx, bus.rf_data_in}), 64'(wq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    v  = '0;
    ix = '{default: '0};
    dt = '{default: '0};
    rows = '{
      '{2'd0, 5'd1,  32'h1111_0001},
      '{2'd1, 5'd2,  32'h2222_0002},
      '{2'd2, 5'd3,  32'h3333_0003},
      '{2'd0, 5'd17, 32'h1111_0011},
      '{2'd1, 5'd18, 32'h2222_0012},
      '{2'd2, 5'd19, 32'h3333_0013}
    };

    // Reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_we",    64'(bus.rf_write_en), 64'(0));
    check("rst_idx",   64'(bus.rf_rd_idx),   64'(0));
    check("rst_data",  64'(bus.rf_data_in),  64'(0));
    check("rst_ready", 64'(bus.req_ready),   64'(0));
    tick();
    rst_n = 1'b1;
    ce    = 1'b1;
    tick();

    // Single LSU write
    v[WB_LSU] = 1'b1; ix[WB_LSU] = 5'd7; dt[WB_LSU] = 32'hDEAD_BEEF;
    gq.push_back(WB_LSU); wq.push_back({5'd7, 32'hDEAD_BEEF});
    #1 check("lsu_ready", 64'(bus.req_ready), 64'(3'b010));
    tick();
    v = '0;
    check("lsu_we",   64'(bus.rf_write_en), 64'(1));
    check("lsu_idx",  64'(bus.rf_rd_idx),   64'(7));
    check("lsu_data", 64'(bus.rf_data_in),  64'(32'hDEAD_BEEF));

    // CSR write brings the pointer back to 0
    v[WB_CSR] = 1'b1; ix[WB_CSR] = 5'd3; dt[WB_CSR] = 32'h3333_3333;
    gq.push_back(WB_CSR); wq.push_back({5'd3, 32'h3333_3333});
    tick();
    v = '0;

    // All three valid for six cycles: 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; ix[i] = rows[i].idx; dt[i] = rows[i].data;
    end
    for (int r = 0; r < 6; r++) begin
      gq.push_back(int'(rows[r].g));
      wq.push_back({rows[r].idx, rows[r].data});
      tick();
      check("rr_we",  64'(bus.rf_write_en), 64'(1));
      check("rr_idx", 64'(bus.rf_rd_idx),   64'(rows[r].idx));
      if (r < 3) begin
        ix[r] = rows[r+3].idx; dt[r] = rows[r+3].data;
      end else begin
        v[r-3] = 1'b0;
      end
    end

    // x0 write: accepted, not enabled, pointer still advances
    v[WB_ALU] = 1'b1; ix[WB_ALU] = 5'd0; dt[WB_ALU] = 32'h0000_1234;
    gq.push_back(WB_ALU);
    #1 check("x0_ready", 64'(bus.req_ready), 64'(3'b001));
    tick();
    v = '0;
    check("x0_we",   64'(bus.rf_write_en), 64'(0));
    check("x0_data", 64'(bus.rf_data_in),  64'(32'h0000_1234));
    v = 3'b111;
    ix[WB_ALU] = 5'd1;  dt[WB_ALU] = 32'hA0A0_0001;
    ix[WB_LSU] = 5'd10; dt[WB_LSU] = 32'hB0B0_0010;
    ix[WB_CSR] = 5'd11; dt[WB_CSR] = 32'hC0C0_0011;
    gq.push_back(WB_LSU); wq.push_back({5'd10, 32'hB0B0_0010});
    #1 check("x0_ptr_ready", 64'(bus.req_ready), 64'(3'b010));
    tick();
    v = '0;

    // ce stall after a transfer: held for 3 cycles, commits once
    v[WB_CSR] = 1'b1; ix[WB_CSR] = 5'd12; dt[WB_CSR] = 32'hCAFE_F00D;
    gq.push_back(WB_CSR); wq.push_back({5'd12, 32'hCAFE_F00D});
    tick();
    ce = 1'b0;
    v  = 3'b001; ix[WB_ALU] = 5'd2; dt[WB_ALU] = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 64'(bus.req_ready),   64'(0));
      check("stall_we",    64'(bus.rf_write_en), 64'(1));
      check("stall_idx",   64'(bus.rf_rd_idx),   64'(12));
      check("stall_data",  64'(bus.rf_data_in),  64'(32'hCAFE_F00D));
      tick();
    end
    v  = '0;
    ce = 1'b1;
    tick();
    check("stall_done_we", 64'(bus.rf_write_en), 64'(0));

    // Same rd from ALU then LSU: later grant lands last
    v = 3'b011;
    ix[WB_ALU] = 5'd4; dt[WB_ALU] = 32'hAAAA_0001;
    ix[WB_LSU] = 5'd4; dt[WB_LSU] = 32'hBBBB_0002;
    gq.push_back(WB_ALU); wq.push_back({5'd4, 32'hAAAA_0001});
    gq.push_back(WB_LSU); wq.push_back({5'd4, 32'hBBBB_0002});
    tick();
    v[WB_ALU] = 1'b0;
    tick();
    v = '0;
    check("same_rd_data", 64'(bus.rf_data_in), 64'(32'hBBBB_0002));

`ifdef REGFILE_WB_FWD_EN
    // Forward compare against the staged write
    v[WB_CSR] = 1'b1; ix[WB_CSR] = 5'd5; dt[WB_CSR] = 32'h5555_5555;
    gq.push_back(WB_CSR); wq.push_back({5'd5, 32'h5555_5555});
    tick();
    v = '0;
    bus.rs1_idx = 5'd5; bus.rs2_idx = 5'd0;
    #1;
    check("fwd_rs1_hit", 64'(bus.rs1_hit), 64'(1));
    check("fwd_rs2_hit", 64'(bus.rs2_hit), 64'(0));
    tick();
    check("fwd_idle_hit", 64'(bus.rs1_hit), 64'(0));
`endif

    // Reset mid-cycle drops a staged write immediately
    v[WB_CSR] = 1'b1; ix[WB_CSR] = 5'd9; dt[WB_CSR] = 32'h9999_9999;
    gq.push_back(WB_CSR);
    tick();
    v = '0;
    check("pre_rst_we", 64'(bus.rf_write_en), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_we",   64'(bus.rf_write_en), 64'(0));
    check("midrst_idx",  64'(bus.rf_rd_idx),   64'(0));
    check("midrst_data", 64'(bus.rf_data_in),  64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Pointer restarts at 0 after reset
    v = 3'b111;
    ix[WB_ALU] = 5'd6;  dt[WB_ALU] = 32'h6666_0006;
    ix[WB_LSU] = 5'd13; dt[WB_LSU] = 32'h6666_0013;
    ix[WB_CSR] = 5'd14; dt[WB_CSR] = 32'h6666_0014;
    gq.push_back(WB_ALU); wq.push_back({5'd6, 32'h6666_0006});
    #1 check("post_rst_ready", 64'(bus.req_ready), 64'(3'b001));
    tick();
    v = '0;
    tick();
    tick();

    check("grant_q_empty",  64'(gq.size()), 64'(0));
    check("commit_q_empty", 64'(wq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
